// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: req/ack bus access with stall and MEM/WB bubbles
// Optional access timeout with sticky error flag enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] aluresult_in,
  input  logic [DATA_W-1:0] writedata_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] readdata_out,
  output logic [DATA_W-1:0] resultalu_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              memtoreg_out,
  output logic              regwrite_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              access;

  // A simultaneous read+write request is treated as a store.
  assign access = memread_in | memwrite_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    stall_out   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_out   = 1'b1;
          state_d     = WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = memwrite_in;
          bus_addr_d  = aluresult_in[ADDR_W-1:0];
          bus_wdata_d = writedata_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          rdata_d   = bus_we_q ? '0 : bus_rdata;
          state_d   = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // An ack on the final cycle wins over the timeout.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          rdata_d   = '1;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bubble the MEM/WB inputs while stalled so nothing commits twice.
    readdata_out  = rdata_q;
    resultalu_out = stall_out ? '0 : aluresult_in;
    rd_out        = stall_out ? '0 : rd_in;
    memtoreg_out  = stall_out ? 1'b0 : memtoreg_in;
    regwrite_out  = stall_out ? 1'b0 : regwrite_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err_out = err_q;
`else
  assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and randomized checks of mem_access_stage against a transaction-level model
module tb_mem_access_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] aluresult_in, writedata_in, bus_rdata;
  logic [4:0] rd_in;
  logic       memread_in, memwrite_in, memtoreg_in, regwrite_in, bus_ack;
  logic       stall_out, memtoreg_out, regwrite_out, bus_req, bus_we, bus_err_out;
  logic [7:0] readdata_out, resultalu_out, bus_addr, bus_wdata;
  logic [4:0] rd_out;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] last_rd = 8'h00;
  logic       exp_err = 1'b0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .aluresult_in(aluresult_in), .writedata_in(writedata_in), .rd_in(rd_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .stall_out(stall_out), .readdata_out(readdata_out), .resultalu_out(resultalu_out),
    .rd_out(rd_out), .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction held at the inputs until the stage releases it; n_wait is the ack cycle.
  task automatic do_instr(input logic [7:0] alu, input logic [7:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic mtr, input logic rw,
                          input int n_wait, input logic [7:0] rdata, input logic ack_timeout);
    aluresult_in = alu; writedata_in = wd; rd_in = rd;
    memread_in = mr; memwrite_in = mw; memtoreg_in = mtr; regwrite_in = rw;
    bus_ack = 1'b0;
    if (!(mr | mw)) begin
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("alu_stall", stall_out, 0);
      chk("alu_result", resultalu_out, alu);
      chk("alu_rd", rd_out, rd);
      chk("alu_memtoreg", memtoreg_out, mtr);
      chk("alu_regwrite", regwrite_out, rw);
      chk("alu_readdata", readdata_out, last_rd);
      chk("alu_bus_req", bus_req, 0);
      step();
      bus_ack = 1'b0;
      return;
    end
    @(negedge clk);
    chk("idle_stall", stall_out, 1);
    chk("idle_bubble", {resultalu_out, rd_out, memtoreg_out, regwrite_out}, 0);
    chk("idle_bus_req", bus_req, 0);
    step();
    for (int k = 1; k <= n_wait; k++) begin
      bus_ack = (k == n_wait) && !ack_timeout;
      bus_rdata = (k == n_wait) ? rdata : 8'($urandom);
      @(negedge clk);
      chk("wait_stall", stall_out, 1);
      chk("wait_bus_req", bus_req, 1);
      chk("wait_bus_we", bus_we, mw);
      chk("wait_bus_addr", bus_addr, alu);
      chk("wait_bus_wdata", bus_wdata, wd);
      chk("wait_bubble", {resultalu_out, rd_out, memtoreg_out, regwrite_out}, 0);
      step();
    end
    bus_ack = 1'($urandom_range(0, 1));
    if (ack_timeout) begin
      last_rd = 8'hFF;
      exp_err = 1'b1;
    end else begin
      last_rd = mw ? 8'h00 : rdata;
    end
    @(negedge clk);
    chk("done_stall", stall_out, 0);
    chk("done_bus_req", bus_req, 0);
    chk("done_readdata", readdata_out, last_rd);
    chk("done_result", resultalu_out, alu);
    chk("done_rd", rd_out, rd);
    chk("done_memtoreg", memtoreg_out, mtr);
    chk("done_regwrite", regwrite_out, rw);
    chk("done_err", bus_err_out, exp_err);
    step();
    bus_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    aluresult_in = 8'h00; writedata_in = 8'h00; rd_in = 5'd0; bus_rdata = 8'h00;
    memread_in = 1'b0; memwrite_in = 1'b0; memtoreg_in = 1'b0; regwrite_in = 1'b0;
    bus_ack = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 0);
    chk("rst_readdata", readdata_out, 0);
    chk("rst_err", bus_err_out, 0);
    chk("rst_stall", stall_out, 0);
    step();
    reset = 1'b0;

    do_instr(8'h3C, 8'h00, 5'd7, 0, 0, 0, 1, 0, 8'h00, 0);
    do_instr(8'h10, 8'h00, 5'd3, 1, 0, 1, 1, 1, 8'hA5, 0);
    do_instr(8'h20, 8'h5A, 5'd0, 0, 1, 0, 0, 4, 8'h77, 0);
    do_instr(8'h44, 8'hC3, 5'd9, 1, 1, 0, 0, 2, 8'h99, 0);
    do_instr(8'h01, 8'h00, 5'd1, 0, 0, 0, 1, 0, 8'h00, 0);

    // Reset during WAIT abandons the access and clears the load latch.
    do_instr(8'h30, 8'h00, 5'd2, 1, 0, 1, 1, 1, 8'h6B, 0);
    aluresult_in = 8'h50; memread_in = 1'b1; memwrite_in = 1'b0; bus_ack = 1'b0;
    step();
    @(negedge clk);
    chk("rstwait_in_wait", bus_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    memread_in = 1'b0; regwrite_in = 1'b0;
    last_rd = 8'h00; exp_err = 1'b0;
    @(negedge clk);
    chk("rstwait_bus_req", bus_req, 0);
    chk("rstwait_stall", stall_out, 0);
    chk("rstwait_readdata", readdata_out, 0);
    step();

`ifdef MEM_TIMEOUT_EN
    do_instr(8'h60, 8'h00, 5'd4, 1, 0, 1, 1, 15, 8'hC7, 0);
    do_instr(8'h61, 8'h00, 5'd5, 1, 0, 1, 1, 15, 8'h00, 1);
    do_instr(8'h62, 8'h00, 5'd6, 0, 0, 0, 1, 0, 8'h00, 0);
    @(negedge clk);
    chk("to_err_sticky", bus_err_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_rd = 8'h00; exp_err = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", bus_err_out, 0);
    step();
`else
    do_instr(8'h60, 8'h00, 5'd4, 1, 0, 1, 1, 20, 8'hC7, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [2:0] kind;
      kind = 3'($urandom_range(0, 7));
      do_instr(8'($urandom), 8'($urandom), 5'($urandom), kind[0] & kind[2], kind[1] & kind[2],
               1'($urandom), 1'($urandom), $urandom_range(1, 6), 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 8-bit pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Runs loads and stores over a simple req/ack data bus, stalls the upstream pipeline while an access is outstanding, and drives the MEM/WB inputs: readdata, resultalu, rd, memtoreg, regwrite.
- Non-memory instructions pass through in zero cycles with no stall.

Parameters:
- DATA_W, 8, data width of bus, ALU result and load data
- ADDR_W, 8, bus address width; taken from the low bits of aluresult_in
- RD_W, 5, destination register index width
- TIMEOUT_CYCLES, 15, WAIT cycles before abort; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- aluresult_in  in  DATA_W  ALU result; memory address for loads and stores
- writedata_in  in  DATA_W  store data
- rd_in  in  RD_W  destination register
- memread_in  in  1  load request
- memwrite_in  in  1  store request
- memtoreg_in  in  1  writeback source select
- regwrite_in  in  1  register write enable
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- readdata_out  out  DATA_W  load data to MEM/WB
- resultalu_out  out  DATA_W  ALU result to MEM/WB
- rd_out  out  RD_W  to MEM/WB
- memtoreg_out  out  1  to MEM/WB
- regwrite_out  out  1  to MEM/WB
- bus_req  out  1  access request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  ADDR_W  registered
- bus_wdata  out  DATA_W  registered
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  access complete, single-cycle pulse
- bus_err_out  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset state and output values:
  - State is IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, internal read latch and bus_err_out are all 0.
  - Reset during WAIT abandons the access; bus_req is 0 after that edge.
- Access request: access = memread_in | memwrite_in. If both are 1, the access is a store; memread is ignored.
- IDLE with access = 0:
  - stall_out = 0; stay in IDLE.
  - Outputs pass through combinationally; readdata_out = latch value.
- IDLE with access = 1:
  - stall_out = 1.
  - On the clock edge: go to WAIT; bus_req = 1; bus_we = memwrite_in; bus_addr = aluresult_in[ADDR_W-1:0]; bus_wdata = writedata_in.
- WAIT:
  - stall_out = 1; bus signals hold stable.
  - bus_ack sampled high at an edge: bus_req = 0, bus_we = 0, go to DONE.
  - On that edge, latch = bus_rdata for a load, 0 for a store.
- DONE:
  - stall_out = 0; the instruction is still held at the inputs.
  - Outputs pass through, with readdata_out = latch.
  - The access is not re-issued. Next edge: IDLE.
- Bubbles: while stall_out = 1, regwrite_out = 0, memtoreg_out = 0, rd_out = 0, resultalu_out = 0. No duplicate or partial commits reach MEM/WB.
- Latency:
  - Non-memory instruction: 1 cycle through the stage.
  - Memory instruction: 2 + N cycles, where N ≥ 1 is the number of WAIT cycles up to and including the ack. The minimum is 3 cycles.
- Spurious bus_ack in IDLE or DONE is ignored.
- readdata_out holds the last load value until the next completed access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter is cleared on entry to WAIT.
  - If TIMEOUT_CYCLES WAIT cycles elapse without ack: drop bus_req, latch = all-ones (8'hFF), set bus_err_out = 1 (sticky until reset), go to DONE.
  - An ack arriving on the timeout edge takes priority and completes the access normally.
- Undefined: WAIT lasts until ack with no limit; bus_err_out is tied 0; no counter logic is present.

Test Plan:
- Reset, then ALU op with aluresult_in = 8'h3C, rd_in = 7, regwrite_in = 1 → same cycle: resultalu_out = 8'h3C, rd_out = 7, regwrite_out = 1, stall_out = 0; bus_req stays 0.
- Load from 8'h10, bus acks in the first WAIT cycle with 8'hA5 → stall_out high for 2 cycles; DONE cycle: readdata_out = 8'hA5, memtoreg_out = 1, regwrite_out = 1; total 3 cycles.
- Store 8'h5A to 8'h20 with ack after 4 WAIT cycles → bus_we = 1, bus_addr = 8'h20, bus_wdata = 8'h5A held stable throughout; regwrite_out = 0 during stall; readdata_out = 0 in DONE.
- memread_in = memwrite_in = 1 → bus_we = 1 (store). bus_ack pulse while IDLE → no state change, stall_out = 0.
- Reset asserted in WAIT → next cycle: bus_req = 0, state IDLE, stall_out = 0 (given access = 0 at the inputs).
- With MEM_TIMEOUT_EN, load with no ack → after 15 WAIT cycles: bus_req = 0, readdata_out = 8'hFF, bus_err_out = 1, which stays 1 until reset.
